// File: rtl/pc_gen_pkg.sv
// Shared defaults and next-PC source encoding for the fetch PC generator.
package pc_gen_pkg;

    localparam int unsigned DefStep        = 4;
    localparam logic [31:0] DefResetVector = 32'h0000_0000;

    typedef enum logic [2:0] {
        SRC_RESET,
        SRC_REDIRECT,
        SRC_HOLD,
        SRC_CALLRET,
        SRC_RET,
        SRC_CALL,
        SRC_SEQ
    } pc_src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push at ptr, pop from ptr-1, replace top in place.
module pc_ras
    import pc_gen_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned RAS_DEPTH = 4,
    localparam int unsigned PtrW     = $clog2(RAS_DEPTH),
    localparam int unsigned CntW     = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             replace,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] top,
    output logic [CntW-1:0]  count
);

    localparam logic [CntW-1:0] FullCount = CntW'(RAS_DEPTH);

    logic [WIDTH-1:0] mem_q [RAS_DEPTH];
    logic [PtrW-1:0]  ptr_q, ptr_d, ptr_m1;
    logic [CntW-1:0]  count_q, count_d;

    assign ptr_m1 = ptr_q - PtrW'(1);

    always_comb begin
        ptr_d   = ptr_q;
        count_d = count_q;
        if (push) begin
            ptr_d = ptr_q + PtrW'(1);
            // A push into a full stack overwrites the oldest entry; depth saturates.
            if (count_q != FullCount) begin
                count_d = count_q + CntW'(1);
            end
        end else if (pop) begin
            ptr_d = ptr_m1;
            if (count_q != '0) begin
                count_d = count_q - CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q   <= '0;
            count_q <= '0;
        end else begin
            ptr_q   <= ptr_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[ptr_q] <= wdata;
        end else if (replace) begin
            mem_q[ptr_m1] <= wdata;
        end
    end

    assign top   = mem_q[ptr_m1];
    assign count = count_q;

endmodule

// File: rtl/pc_gen.sv
// IF-stage program counter: prioritised redirect/stall/call/return/sequential update
// with a return-address stack steering returns.
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DefResetVector),
    parameter int unsigned      STEP         = DefStep,
    parameter int unsigned      RAS_DEPTH    = 4,
    localparam int unsigned     CntW         = $clog2(RAS_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [WIDTH-1:0] redirect_target,
    input  logic             call_valid,
    input  logic [WIDTH-1:0] call_target,
    input  logic [WIDTH-1:0] call_ret_addr,
    input  logic             ret_valid,
    input  logic [WIDTH-1:0] ret_target,
    output logic [WIDTH-1:0] pc,
    output logic [CntW-1:0]  ras_count,
    output logic             ras_empty,
    output logic             ras_full,
    output logic             ret_miss
);

    pc_src_e          src;
    logic [WIDTH-1:0] pc_q, pc_d;
    logic             ret_miss_q, ret_miss_d;
    logic             ras_push, ras_pop, ras_replace;
    logic [WIDTH-1:0] ras_top;

    always_comb begin
        if (!rst_n) begin
            src = SRC_RESET;
        end else if (redirect_valid) begin
            src = SRC_REDIRECT;
        end else if (stall) begin
            src = SRC_HOLD;
        end else if (call_valid && ret_valid) begin
            src = SRC_CALLRET;
        end else if (ret_valid) begin
            src = SRC_RET;
        end else if (call_valid) begin
            src = SRC_CALL;
        end else begin
            src = SRC_SEQ;
        end
    end

    // Call+return on an empty stack degenerates to a plain push.
    always_comb begin
        ras_push    = (src == SRC_CALL) || ((src == SRC_CALLRET) && ras_empty);
        ras_replace = (src == SRC_CALLRET) && !ras_empty;
        ras_pop     = (src == SRC_RET) && !ras_empty;
        ret_miss_d  = (src == SRC_RET) && ras_empty;
    end

    always_comb begin
        pc_d = pc_q;
        unique case (src)
            SRC_RESET:    pc_d = RESET_VECTOR;
            SRC_REDIRECT: pc_d = redirect_target;
            SRC_HOLD:     pc_d = pc_q;
            SRC_CALLRET:  pc_d = call_target;
            SRC_RET:      pc_d = ras_empty ? ret_target : ras_top;
            SRC_CALL:     pc_d = call_target;
            SRC_SEQ:      pc_d = pc_q + WIDTH'(STEP);
            default:      pc_d = pc_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VECTOR;
            ret_miss_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ret_miss_q <= ret_miss_d;
        end
    end

    pc_ras #(
        .WIDTH     (WIDTH),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (ras_push),
        .pop     (ras_pop),
        .replace (ras_replace),
        .wdata   (call_ret_addr),
        .top     (ras_top),
        .count   (ras_count)
    );

    assign pc        = pc_q;
    assign ret_miss  = ret_miss_q;
    assign ras_empty = (ras_count == '0);
    assign ras_full  = (ras_count == CntW'(RAS_DEPTH));

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues hand-computed results, monitor checks them.
module tb_pc_gen;

    localparam int unsigned W = 32;
    localparam int unsigned D = 4;
    localparam int unsigned CW = $clog2(D + 1);

    typedef struct {
        string          name;
        logic [W-1:0]   pc;
        logic [CW-1:0]  cnt;
        logic           miss;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n, stall, redirect_valid, call_valid, ret_valid;
    logic [W-1:0]  redirect_target, call_target, call_ret_addr, ret_target;
    logic [W-1:0]  pc;
    logic [CW-1:0] ras_count;
    logic          ras_empty, ras_full, ret_miss;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_gen #(
        .WIDTH        (W),
        .RESET_VECTOR (32'h0),
        .STEP         (4),
        .RAS_DEPTH    (D)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .call_valid      (call_valid),
        .call_target     (call_target),
        .call_ret_addr   (call_ret_addr),
        .ret_valid       (ret_valid),
        .ret_target      (ret_target),
        .pc              (pc),
        .ras_count       (ras_count),
        .ras_empty       (ras_empty),
        .ras_full        (ras_full),
        .ret_miss        (ret_miss)
    );

    task automatic chk(input string name, input string field, input logic [W-1:0] act,
                       input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
        end
    endtask

    // Every output is expected to settle after one edge; sample mid-cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            chk(e.name, "pc", pc, e.pc);
            chk(e.name, "ras_count", W'(ras_count), W'(e.cnt));
            chk(e.name, "ret_miss", W'(ret_miss), W'(e.miss));
            chk(e.name, "ras_empty", W'(ras_empty), W'(e.cnt == 0));
            chk(e.name, "ras_full", W'(ras_full), W'(e.cnt == CW'(D)));
        end
    end

    task automatic step(input string name, input logic rn, input logic st,
                        input logic rv, input logic [W-1:0] rt,
                        input logic cv, input logic [W-1:0] ct, input logic [W-1:0] cra,
                        input logic tv, input logic [W-1:0] tt,
                        input logic [W-1:0] epc, input int ecnt, input logic emiss);
        exp_t e;
        rst_n = rn; stall = st;
        redirect_valid = rv; redirect_target = rt;
        call_valid = cv; call_target = ct; call_ret_addr = cra;
        ret_valid = tv; ret_target = tt;
        @(posedge clk);
        e.name = name; e.pc = epc; e.cnt = CW'(ecnt); e.miss = emiss;
        sb.push_back(e);
        #1;
    endtask

    task automatic idle(input string name, input logic [W-1:0] epc, input int ecnt);
        step(name, 1, 0, 0, 0, 0, 0, 0, 0, 0, epc, ecnt, 0);
    endtask

    task automatic call(input string name, input logic [W-1:0] ct, input logic [W-1:0] cra,
                        input int ecnt);
        step(name, 1, 0, 0, 0, 1, ct, cra, 0, 0, ct, ecnt, 0);
    endtask

    task automatic ret(input string name, input logic [W-1:0] tt, input logic [W-1:0] epc,
                       input int ecnt, input logic emiss);
        step(name, 1, 0, 0, 0, 0, 0, 0, 1, tt, epc, ecnt, emiss);
    endtask

    initial begin
        int drain;
        step("reset0", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        step("reset1", 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0, 0);
        idle("seq4", 32'h4, 0);
        idle("seq8", 32'h8, 0);
        idle("seq12", 32'hC, 0);
        step("redir_top", 1, 0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 0, 0);
        idle("wrap", 32'h0, 0);

        step("redir10", 1, 0, 1, 32'h10, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        step("stall1", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        step("stall2_callret", 1, 1, 0, 0, 1, 32'h123, 32'h77, 1, 32'h88, 32'h10, 0, 0);
        step("stall3", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h10, 0, 0);
        step("stall_redir", 1, 1, 1, 32'h200, 0, 0, 0, 0, 0, 32'h200, 0, 0);

        call("call400", 32'h400, 32'h14, 1);
        step("redir_over_call", 1, 0, 1, 32'h500, 1, 32'h600, 32'h66, 0, 0, 32'h500, 1, 0);
        ret("ret14", 32'h999, 32'h14, 0, 0);

        call("callA0", 32'h600, 32'hA0, 1);
        call("callB0", 32'h610, 32'hB0, 2);
        call("callC0", 32'h620, 32'hC0, 3);
        call("callD0", 32'h630, 32'hD0, 4);
        call("callE0_full", 32'h640, 32'hE0, 4);
        ret("retE0", 32'h1, 32'hE0, 3, 0);
        ret("retD0", 32'h1, 32'hD0, 2, 0);
        ret("retC0", 32'h1, 32'hC0, 1, 0);
        ret("retB0", 32'h1, 32'hB0, 0, 0);
        ret("ret_miss99", 32'h99, 32'h99, 0, 1);
        idle("miss_pulse_end", 32'h9D, 0);

        call("call20", 32'h700, 32'h20, 1);
        step("callret_top", 1, 0, 0, 0, 1, 32'h300, 32'h50, 1, 32'h5, 32'h300, 1, 0);
        ret("ret_replaced", 32'h5, 32'h50, 0, 0);
        step("callret_empty", 1, 0, 0, 0, 1, 32'h300, 32'h60, 1, 32'h5, 32'h300, 1, 0);
        ret("ret60", 32'h5, 32'h60, 0, 0);

        call("c1", 32'h800, 32'h11, 1);
        call("c2", 32'h810, 32'h22, 2);
        call("c3", 32'h820, 32'h33, 3);
        step("mid_reset", 0, 0, 0, 0, 1, 32'h900, 32'h44, 0, 0, 32'h0, 0, 0);
        ret("ret44_miss", 32'h44, 32'h44, 0, 1);
        step("stall_clears_miss", 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h44, 0, 0);
        idle("seq48", 32'h48, 0);

        drain = 0;
        while (sb.size() > 0 && drain < 10) begin
            @(posedge clk);
            drain++;
        end
        #20;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain actual=%0d pending required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
